// File: rtl/adam_pause_seq_pkg.sv
// Shared types and width helpers for the adam_pause_seq pause sequencer.
package adam_pause_seq_pkg;

  typedef enum logic [1:0] {
    RESUMED  = 2'd0,
    PAUSING  = 2'd1,
    PAUSED   = 2'd2,
    RESUMING = 2'd3
  } state_e;

  // Width of the paused-channel count, which spans 0..n inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return unsigned'($clog2(n + 1));
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return unsigned'($clog2(n)) + 1;
  endfunction

endpackage

// File: rtl/adam_pause_seq_timer.sv
// Step watchdog: counts cycles a channel handshake stays open and flags expiry.
module adam_pause_seq_timer #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic busy_i,
  output logic expired_c
);

  localparam int unsigned TmrW = (TIMEOUT > 1) ? unsigned'($clog2(TIMEOUT)) : 1;
  localparam logic [TmrW-1:0] Last = TmrW'(TIMEOUT - 1);

  logic [TmrW-1:0] cnt_q, cnt_d;

  // Expiry is the cycle whose closing edge would bring the count to TIMEOUT.
  assign expired_c = busy_i && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (busy_i && !expired_c) begin
      cnt_d = cnt_q + TmrW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/adam_pause_seq.sv
// Pause sequencer: pauses channels in ascending order, resumes in descending order.
// Optional handshake timeout watchdog enabled by ADAM_PAUSE_SEQ_TIMEOUT_EN.
module adam_pause_seq
  import adam_pause_seq_pkg::*;
#(
  parameter int unsigned NO_CHANNELS = 4,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  pause_req,
  output logic                                  pause_ack,
  output logic [NO_CHANNELS-1:0]                ch_pause_req,
  input  logic [NO_CHANNELS-1:0]                ch_pause_ack,
  output logic                                  err,
  output logic [idx_width(NO_CHANNELS)-1:0]     err_idx
);

  localparam int unsigned CntW = cnt_width(NO_CHANNELS);
  localparam int unsigned IdxW = idx_width(NO_CHANNELS);
  localparam logic [CntW-1:0] CntMax = CntW'(NO_CHANNELS);

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [NO_CHANNELS-1:0] req_q, req_d;
  logic                   ack_q, ack_d;

  logic                   busy_c;
  logic [CntW-1:0]        tgt_c;
  logic                   tgt_ack_c;
  logic                   hit_c;
  logic                   expired_c;
  logic                   step_done_c;
  logic                   new_step_c;
  logic [CntW-1:0]        set_idx_c;

  assign busy_c = (state_q == PAUSING) || (state_q == RESUMING);
  assign tgt_c  = (state_q == RESUMING) ? (cnt_q - CntW'(1)) : cnt_q;

  // Only the current target's acknowledge is observed.
  always_comb begin
    tgt_ack_c = 1'b0;
    for (int unsigned i = 0; i < NO_CHANNELS; i++) begin
      if (CntW'(i) == tgt_c) begin
        tgt_ack_c = ch_pause_ack[i];
      end
    end
  end

  assign hit_c       = ((state_q == PAUSING) && tgt_ack_c) ||
                       ((state_q == RESUMING) && !tgt_ack_c);
  assign step_done_c = hit_c || (busy_c && expired_c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= PAUSED;
      cnt_q   <= CntMax;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: pause_req is only consulted at idle or at a step boundary.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RESUMED: begin
        if (pause_req) state_d = PAUSING;
      end
      PAUSED: begin
        if (!pause_req) state_d = RESUMING;
      end
      PAUSING: begin
        if (step_done_c) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d == CntMax) begin
            state_d = PAUSED;
          end else if (!pause_req) begin
            state_d = RESUMING;
          end
        end
      end
      RESUMING: begin
        if (step_done_c) begin
          cnt_d = cnt_q - CntW'(1);
          if (cnt_d == '0) begin
            state_d = RESUMED;
          end else if (pause_req) begin
            state_d = PAUSING;
          end
        end
      end
      default: begin
        state_d = PAUSED;
        cnt_d   = CntMax;
      end
    endcase
  end

  // Outputs: a new step moves exactly one channel request toward the new direction.
  always_comb begin
    req_d      = req_q;
    ack_d      = (state_d == PAUSED);
    new_step_c = 1'b0;
    set_idx_c  = (state_d == PAUSING) ? cnt_d : (cnt_d - CntW'(1));
    if (!busy_c && (state_d != state_q)) begin
      new_step_c = 1'b1;
    end else if (busy_c && step_done_c &&
                 ((state_d == PAUSING) || (state_d == RESUMING))) begin
      new_step_c = 1'b1;
    end
    if (new_step_c) begin
      for (int unsigned i = 0; i < NO_CHANNELS; i++) begin
        if (CntW'(i) == set_idx_c) begin
          req_d[i] = (state_d == PAUSING);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q <= '1;
      ack_q <= 1'b1;
    end else begin
      req_q <= req_d;
      ack_q <= ack_d;
    end
  end

  assign ch_pause_req = req_q;
  assign pause_ack    = ack_q;

`ifdef ADAM_PAUSE_SEQ_TIMEOUT_EN
  logic            force_c;
  logic            err_q, err_d;
  logic [IdxW-1:0] err_idx_q, err_idx_d;

  adam_pause_seq_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .start_i   (new_step_c),
    .busy_i    (busy_c),
    .expired_c (expired_c)
  );

  // A step closed by the watchdog rather than the channel is an error.
  assign force_c = busy_c && expired_c && !hit_c;

  always_comb begin
    err_d     = err_q | force_c;
    err_idx_d = (force_c && !err_q) ? IdxW'(tgt_c) : err_idx_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q     <= 1'b0;
      err_idx_q <= '0;
    end else begin
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign err     = err_q;
  assign err_idx = err_idx_q;
`else
  logic unused_timeout;

  assign unused_timeout = ^32'(TIMEOUT);
  assign expired_c      = 1'b0;
  assign err            = 1'b0;
  assign err_idx        = '0;
`endif

endmodule

// File: doc/adam_pause_seq.md
Name: adam_pause_seq

Overview:
- Pause sequencer that fans one global pause_req/pause_ack pair out to NO_CHANNELS downstream pause-able units (AXI-Lite pause bridges, peripherals).
- Pauses channels strictly one at a time in ascending index order.
- Resumes them one at a time in descending index order, so a master is always paused before the interconnect it drives.
- Sits between the system power/debug controller and the per-bus pause bridges.

Parameters:
- NO_CHANNELS, 4, number of downstream pause channels; legal range 1..32.
- TIMEOUT, 1023, maximum cycles one channel handshake may take before it is flagged (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset; asserted when 0.
- pause_req  in  1  global pause request.
- pause_ack  out  1  global acknowledge; 1 = every channel is paused.
- ch_pause_req  out  NO_CHANNELS  per-channel pause request, registered.
- ch_pause_ack  in  NO_CHANNELS  per-channel pause acknowledge.
- err  out  1  sticky handshake-timeout flag.
- err_idx  out  $clog2(NO_CHANNELS)+1  index of the first channel that timed out.

Behaviour:
- Reset values (asynchronous, while rst=0):
  - ch_pause_req = all 1; pause_ack = 1; cnt = NO_CHANNELS; state = PAUSED.
  - err = 0; err_idx = 0.
  - The system therefore comes up paused.
- cnt is a $clog2(NO_CHANNELS+1)-bit count of channels currently paused. Channels 0..cnt-1 are paused.
- Per-channel handshake is 4-phase:
  - pause: req 0->1, then wait for ack=1.
  - resume: req 1->0, then wait for ack=0.
  - A channel's req never changes while its own step is still open.
- States:
  - RESUMED (cnt=0, pause_ack=0).
  - PAUSING.
  - PAUSED (cnt=NO_CHANNELS, pause_ack=1).
  - RESUMING.
- Transitions:
  - RESUMED & pause_req=1 -> PAUSING. ch_pause_req[0] rises on the same edge.
  - PAUSED & pause_req=0 -> RESUMING. ch_pause_req[NO_CHANNELS-1] falls on the same edge.
- PAUSING step (target channel = cnt):
  - The step completes on the edge where ch_pause_ack[cnt]=1 is sampled; cnt increments on that edge.
  - If cnt reaches NO_CHANNELS: go to PAUSED and set pause_ack=1 on that edge.
  - Otherwise, if pause_req=1: ch_pause_req[cnt+1] rises on the same edge.
- RESUMING step (target channel = cnt-1):
  - The step completes on the edge where ch_pause_ack[cnt-1]=0 is sampled; cnt decrements on that edge.
  - If cnt reaches 0: go to RESUMED.
  - Otherwise, if pause_req=0: ch_pause_req[cnt-2] falls on the same edge.
- pause_ack falls on the edge that leaves PAUSED.
- Reversal:
  - pause_req is sampled only at step boundaries. A step in progress always completes; it is never aborted.
  - PAUSING with pause_req=0 at a boundary -> RESUMING. The next step drops ch_pause_req[new cnt-1], i.e. the channel just paused.
  - RESUMING with pause_req=1 at a boundary -> PAUSING. The next step raises ch_pause_req[new cnt].
- Latency, with each ack returned one cycle after its req changes:
  - Full pause = 2*NO_CHANNELS cycles from pause_req to pause_ack.
  - Full resume = 2*NO_CHANNELS cycles.
- ack is ignored on every channel other than the current target.
- Reset asserted mid-sequence returns immediately to the reset state (all requests high). Downstream units are expected to be reset by the same rst.
- NO_CHANNELS=1 is legal; then PAUSING and RESUMING each last exactly one step.

Optional Feature:
- Macro: ADAM_PAUSE_SEQ_TIMEOUT_EN.
- Defined:
  - A step counter clears at each step start and increments every cycle while the step is open.
  - When the counter reaches TIMEOUT, the step is forced complete (cnt updates as if acked) and err is set.
  - err_idx latches the channel index only on the first error. err stays sticky until reset.
  - The stuck channel's req keeps its new level.
- Undefined: no counter; a step waits indefinitely; err and err_idx are tied to 0.

Decomposition:
- Package adam_pause_seq_pkg:
  - state enum (RESUMED, PAUSING, PAUSED, RESUMING).
  - Helper function computing the cnt width from NO_CHANNELS.
- One sub-module, adam_pause_seq_timer:
  - Inputs: start, busy, TIMEOUT.
  - Output: expired.
  - Instantiated only when ADAM_PAUSE_SEQ_TIMEOUT_EN is defined.

Test Plan:
- Reset: rst=0 for 3 cycles with pause_req=1 -> ch_pause_req=4'b1111, pause_ack=1, err=0. Hold pause_req=1 after release -> no change.
- Resume: drop pause_req, channel models ack after 1 cycle -> ch_pause_req falls in order 3,2,1,0, one every 2 cycles. pause_ack falls at the first step. State RESUMED after 8 cycles.
- Pause: raise pause_req -> ch_pause_req rises in order 0,1,2,3, one every 2 cycles. pause_ack=1 exactly 8 cycles after pause_req.
- Reversal: drop pause_req while ch1 pausing with ack delayed 5 cycles -> ch1 req held until ack=1. Then ch1 req falls, then ch0 req falls. pause_ack never rises.
- Out-of-order ack: assert ch_pause_ack[3]=1 while ch0 is the target -> ignored. cnt advances only on ch0's ack.
- Timeout (macro defined, TIMEOUT=16): ch2 never acks -> step forced at 16 cycles; err=1, err_idx=2. Sequence finishes and pause_ack=1. A later ch1 timeout leaves err_idx=2.
